// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Brief    : Wishbone master that buffers single-word commands in a FIFO and
//            issues them one at a time, returning one response per command.
//            Optional WAIT timeout enabled by defining WB_CMD_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module wb_cmd_master #(
    parameter int A_WIDTH = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [3:0]              cmd_we_i,
    input  logic [A_WIDTH:0]        cmd_addr_i,
    input  logic [31:0]             cmd_data_i,
    output logic                    rsp_valid_o,
    output logic [31:0]             rsp_data_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic                    busy_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    wb_stb_o,
    output logic [A_WIDTH:0]        wb_addr_o,
    output logic [3:0]              wb_we_o,
    output logic [31:0]             wb_data_o,
    input  logic [31:0]             wb_data_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_stall_i
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1) || (TIMEOUT > 256)) begin : g_cfg_check
        $error("wb_cmd_master: DEPTH must be a power of 2 >= 2 and TIMEOUT in 1..256");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_we_mem   [DEPTH];
    logic [A_WIDTH:0]    r_addr_mem [DEPTH];
    logic [31:0]         r_data_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic [3:0]          r_wb_we;
    logic [A_WIDTH:0]    r_wb_addr;
    logic [31:0]         r_wb_data;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [31:0]         r_rsp_data;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_done;
    logic                w_tmo;
    logic                w_fail;

    assign w_full  = (r_level == c_LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = cmd_valid_i && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_fail  = wb_err_i | w_tmo;

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_we_mem[r_wr_ptr]   <= cmd_we_i;
            r_addr_mem[r_wr_ptr] <= cmd_addr_i;
            r_data_mem[r_wr_ptr] <= cmd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                // Ack/err are only meaningful on the edge that accepts the strobe.
                if (!wb_stall_i) begin
                    if (wb_ack_i || wb_err_i) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wb_ack_i || wb_err_i || w_tmo) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wb_we     <= '0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_wb_we   <= r_we_mem[r_rd_ptr];
                r_wb_addr <= r_addr_mem[r_rd_ptr];
                r_wb_data <= r_data_mem[r_rd_ptr];
            end
            r_rsp_valid <= w_done;
            r_rsp_err   <= w_done & w_fail;
            r_rsp_data  <= (w_done && !w_fail && (r_wb_we == 4'd0)) ? wb_data_i : '0;
        end
    end

`ifdef WB_CMD_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_rsp_tmo;

    assign w_tmo = (r_state == S_WAIT) && !wb_ack_i && !wb_err_i
                   && (r_tmo_cnt == 8'(TIMEOUT - 1));

    // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
            r_rsp_tmo <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == S_WAIT) ? r_tmo_cnt + 8'd1 : 8'd0;
            r_rsp_tmo <= w_tmo;
        end
    end

    assign rsp_timeout_o = r_rsp_tmo;
`else
    assign w_tmo         = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    assign cmd_ready_o = !w_full;
    assign level_o     = r_level;
    assign busy_o      = (r_state != S_IDLE) || !w_empty;
    assign wb_stb_o    = (r_state == S_REQ);
    assign wb_addr_o   = r_wb_addr;
    assign wb_we_o     = r_wb_we;
    assign wb_data_o   = r_wb_data;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_data_o  = r_rsp_data;

endmodule
`default_nettype wire
